// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state codes,
// requester owner codes, the latched transaction control fields and the
// round-robin grant decision.
package mem_arbiter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    // Control fields frozen at grant time for the transaction in flight.
    typedef struct packed {
        logic owner;
        logic we;
    } txn_ctl_t;

    // Loader wins when it is the only eligible requester, or when both are
    // eligible and the CPU was the last one served.
    function automatic logic pick_ldr(input logic cpu_ok, input logic ldr_ok,
                                      input logic rr_last);
        return ldr_ok && (!cpu_ok || (rr_last == OWN_CPU));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter; one instance for the CPU and one
// for the program loader.
//
// Handshake: the requester raises req with we/addr/wdata stable and holds it
// until ack. ack is a single-cycle completion pulse; rdata is registered and
// stays valid from ack until the next read of that requester completes.
// Dropping req before ack is a protocol violation; the transaction still
// completes and is acknowledged.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input ack, input rdata);
    modport slave  (input req, input we, input addr, input wdata,
                    output ack, output rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single unified memory between the CPU and the program loader.
// One transaction in flight, round-robin on ties, loader lock-out of the CPU,
// fixed IDLE->ISSUE->WAIT->CAPTURE->ACK->IDLE sequence per transaction.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      ldr,
    input  logic              ldr_lock,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        state
);

    // Number of WAIT cycles after ISSUE before the read data is valid.
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    logic [2:0]        state_q;
    logic [2:0]        cnt_q;
    logic              rr_last_q;
    txn_ctl_t          ctl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;

    logic cpu_ok;
    logic ldr_ok;
    logic grant_ldr;
    logic issue;
    logic cpu_ack;
    logic ldr_ack;

    // Eligibility and round-robin pick for the current IDLE cycle.
    always_comb begin
        cpu_ok    = cpu.req & ~ldr_lock;
        ldr_ok    = ldr.req;
        grant_ldr = pick_ldr(cpu_ok, ldr_ok, rr_last_q);
    end

    // Transaction FSM, latency counter, latched request and read-data registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            rr_last_q   <= OWN_LDR;
            ctl_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_ok || ldr_ok) begin
                        ctl_q.owner <= grant_ldr ? OWN_LDR : OWN_CPU;
                        ctl_q.we    <= grant_ldr ? ldr.we : cpu.we;
                        addr_q      <= grant_ldr ? ldr.addr : cpu.addr;
                        wdata_q     <= grant_ldr ? ldr.wdata : cpu.wdata;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= LAT_M1;
                    state_q <= (LAT_M1 != 3'd0) ? ST_WAIT : ST_CAPTURE;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!ctl_q.we) begin
                        if (ctl_q.owner == OWN_LDR) begin
                            ldr_rdata_q <= mem_rdata;
                        end else begin
                            cpu_rdata_q <= mem_rdata;
                        end
                    end
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    rr_last_q <= ctl_q.owner;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory strobe and owner acks decoded from state; memory bus is zero outside ISSUE.
    always_comb begin
        issue     = (state_q == ST_ISSUE);
        cpu_ack   = (state_q == ST_ACK) && (ctl_q.owner == OWN_CPU);
        ldr_ack   = (state_q == ST_ACK) && (ctl_q.owner == OWN_LDR);
        mem_en    = issue;
        mem_we    = issue & ctl_q.we;
        mem_addr  = issue ? addr_q : '0;
        mem_wdata = issue ? wdata_q : '0;
    end

    assign cpu.ack   = cpu_ack;
    assign ldr.ack   = ldr_ack;
    assign cpu.rdata = cpu_rdata_q;
    assign ldr.rdata = ldr_rdata_q;
    assign cpu_stall = cpu.req & ~cpu_ack;
    assign state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3, each with a small behavioural memory that only drives valid read
// data in the cycle the data is due.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ldr_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu3_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ldr3_bus ();

    logic        ldr_lock, ldr_lock3;
    logic        cpu_stall, cpu_stall3;
    logic        mem_en, mem_we, mem_en3, mem_we3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
    logic [2:0]  state, state3;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .cpu(cpu_bus), .ldr(ldr_bus),
        .ldr_lock(ldr_lock), .cpu_stall(cpu_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(state)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .cpu(cpu3_bus), .ldr(ldr3_bus),
        .ldr_lock(ldr_lock3), .cpu_stall(cpu_stall3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .state(state3)
    );

    // 16-word memory, 1-cycle read latency, garbage when no read is due.
    logic [31:0] mem [0:15];
    logic [31:0] rd_word;
    logic        rd_vld;
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h00500113;
            rd_vld  <= 1'b0;
            rd_word <= 32'h0;
        end else begin
            rd_vld <= mem_en && !mem_we;
            if (mem_en) begin
                if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
                else        rd_word <= mem[mem_addr[5:2]];
            end
        end
    end
    assign mem_rdata = rd_vld ? rd_word : 32'hDEADBEEF;

    // 3-cycle latency memory for dut3: fixed read word, garbage otherwise.
    logic [2:0] v3;
    always @(posedge clk) begin
        if (!reset) v3 <= 3'b000;
        else        v3 <= {v3[1:0], mem_en3 & ~mem_we3};
    end
    assign mem_rdata3 = v3[2] ? 32'hC0DE0003 : 32'hDEADBEEF;

    int en_cnt = 0;
    int en3_cnt = 0;
    always @(posedge clk) begin
        if (mem_en)  en_cnt++;
        if (mem_en3) en3_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int gap;
    int ldr_acks;
    int cpu_acks;
    int stall_low;
    int ack_seen;
    int en3_snap;

    initial begin
        cpu_bus.req = 0;  cpu_bus.we = 0;  cpu_bus.addr = 0;  cpu_bus.wdata = 0;
        ldr_bus.req = 0;  ldr_bus.we = 0;  ldr_bus.addr = 0;  ldr_bus.wdata = 0;
        cpu3_bus.req = 0; cpu3_bus.we = 0; cpu3_bus.addr = 0; cpu3_bus.wdata = 0;
        ldr3_bus.req = 0; ldr3_bus.we = 0; ldr3_bus.addr = 0; ldr3_bus.wdata = 0;
        ldr_lock = 0;
        ldr_lock3 = 0;

        // 1: reset for two cycles, then idle with no requests
        reset = 0;
        tick();
        tick();
        reset = 1;
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cpu_ack", 32'(cpu_bus.ack), 32'd0);
        chk("rst_ldr_ack", 32'(ldr_bus.ack), 32'd0);
        chk("rst_cpu_rdata", cpu_bus.rdata, 32'd0);
        chk("rst_ldr_rdata", ldr_bus.rdata, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        tick();
        tick();
        tick();
        chk("idle_state", 32'(state), 32'(ST_IDLE));
        chk("idle_no_mem_en", 32'(en_cnt), 32'd0);

        // 2: CPU read of 0x10, RD_LAT=1
        cpu_bus.req = 1; cpu_bus.we = 0; cpu_bus.addr = 32'h10;
        #1;
        chk("rd_stall_pre", 32'(cpu_stall), 32'd1);
        tick();
        chk("rd_issue_state", 32'(state), 32'(ST_ISSUE));
        chk("rd_mem_en", 32'(mem_en), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_stall_issue", 32'(cpu_stall), 32'd1);
        tick();
        chk("rd_capture_state", 32'(state), 32'(ST_CAPTURE));
        chk("rd_mem_en_low", 32'(mem_en), 32'd0);
        chk("rd_ack_early", 32'(cpu_bus.ack), 32'd0);
        chk("rd_stall_capture", 32'(cpu_stall), 32'd1);
        tick();
        chk("rd_ack", 32'(cpu_bus.ack), 32'd1);
        chk("rd_ldr_ack", 32'(ldr_bus.ack), 32'd0);
        chk("rd_rdata", cpu_bus.rdata, 32'h00500113);
        chk("rd_stall_ack", 32'(cpu_stall), 32'd0);
        cpu_bus.req = 0;
        tick();
        chk("rd_post_state", 32'(state), 32'(ST_IDLE));
        chk("rd_post_ack", 32'(cpu_bus.ack), 32'd0);
        chk("rd_rdata_hold", cpu_bus.rdata, 32'h00500113);
        tick();
        chk("rd_no_regrant", 32'(state), 32'(ST_IDLE));

        // 3: simultaneous writes from a fresh reset, CPU wins the first tie
        reset = 0;
        tick();
        reset = 1;
        cpu_bus.req = 1; cpu_bus.we = 1; cpu_bus.addr = 32'h4; cpu_bus.wdata = 32'hAAAA5555;
        ldr_bus.req = 1; ldr_bus.we = 1; ldr_bus.addr = 32'h8; ldr_bus.wdata = 32'h12345678;
        tick();
        chk("wr_issue_addr", mem_addr, 32'h4);
        chk("wr_issue_we", 32'(mem_we), 32'd1);
        chk("wr_issue_wdata", mem_wdata, 32'hAAAA5555);
        tick();
        tick();
        chk("wr_cpu_ack", 32'(cpu_bus.ack), 32'd1);
        chk("wr_ldr_ack_not_yet", 32'(ldr_bus.ack), 32'd0);
        cpu_bus.req = 0;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            gap++;
            if (ldr_bus.ack) break;
        end
        chk("wr_ack_gap", 32'(gap), 32'd4);
        chk("wr_ldr_ack", 32'(ldr_bus.ack), 32'd1);
        ldr_bus.req = 0;
        tick();
        chk("wr_mem_cpu", mem[1], 32'hAAAA5555);
        chk("wr_mem_ldr", mem[2], 32'h12345678);

        // 4: loader lock keeps the CPU out while the loader streams reads
        ldr_lock = 1;
        cpu_bus.req = 1; cpu_bus.we = 0; cpu_bus.addr = 32'h4;
        ldr_bus.req = 1; ldr_bus.we = 0; ldr_bus.addr = 32'h8;
        ldr_acks = 0; cpu_acks = 0; stall_low = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (ldr_bus.ack) ldr_acks++;
            if (cpu_bus.ack) cpu_acks++;
            if (!cpu_stall)  stall_low++;
        end
        chk("lock_ldr_acks", 32'(ldr_acks), 32'd3);
        chk("lock_cpu_acks", 32'(cpu_acks), 32'd0);
        chk("lock_stall_held", 32'(stall_low), 32'd0);
        chk("lock_ldr_rdata", ldr_bus.rdata, 32'h12345678);
        ldr_lock = 0;
        tick();
        tick();
        chk("unlock_issue_state", 32'(state), 32'(ST_ISSUE));
        chk("unlock_cpu_granted", mem_addr, 32'h4);
        tick();
        tick();
        chk("unlock_cpu_ack", 32'(cpu_bus.ack), 32'd1);
        chk("unlock_cpu_rdata", cpu_bus.rdata, 32'hAAAA5555);
        cpu_bus.req = 0;
        ldr_bus.req = 0;
        tick();

        // 5: RD_LAT=3 read on the second instance
        cpu3_bus.req = 1; cpu3_bus.we = 0; cpu3_bus.addr = 32'h20;
        tick();
        chk("l3_issue", 32'(state3), 32'(ST_ISSUE));
        chk("l3_mem_en", 32'(mem_en3), 32'd1);
        chk("l3_mem_addr", mem_addr3, 32'h20);
        tick();
        chk("l3_wait1", 32'(state3), 32'(ST_WAIT));
        chk("l3_mem_en_low", 32'(mem_en3), 32'd0);
        tick();
        chk("l3_wait2", 32'(state3), 32'(ST_WAIT));
        tick();
        chk("l3_capture", 32'(state3), 32'(ST_CAPTURE));
        chk("l3_ack_early", 32'(cpu3_bus.ack), 32'd0);
        tick();
        chk("l3_ack", 32'(cpu3_bus.ack), 32'd1);
        chk("l3_rdata", cpu3_bus.rdata, 32'hC0DE0003);
        cpu3_bus.req = 0;
        tick();
        chk("l3_ack_pulse", 32'(cpu3_bus.ack), 32'd0);

        // 6: reset while waiting abandons the transaction
        cpu3_bus.req = 1; cpu3_bus.we = 0; cpu3_bus.addr = 32'h24;
        tick();
        tick();
        chk("rw_in_wait", 32'(state3), 32'(ST_WAIT));
        reset = 0;
        cpu3_bus.req = 0;
        en3_snap = en3_cnt;
        tick();
        reset = 1;
        chk("rw_state_idle", 32'(state3), 32'(ST_IDLE));
        chk("rw_no_ack", 32'(cpu3_bus.ack), 32'd0);
        chk("rw_rdata_cleared", cpu3_bus.rdata, 32'd0);
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu3_bus.ack) ack_seen++;
        end
        chk("rw_no_late_ack", 32'(ack_seen), 32'd0);
        chk("rw_no_mem_en", 32'(en3_cnt - en3_snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
